// File: rtl/dat_mem_ctrl_pkg.sv
// rtl/dat_mem_ctrl_pkg.sv - shared types and constants for the data-memory DMA controller
// Provides the controller state enum, default address/data widths and the
// starve-counter width used by the grant arbiter.
package dat_mem_ctrl_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int SW     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dat_mem_grant.sv
// rtl/dat_mem_grant.sv - CPU/DMA arbiter for the single-port data memory
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   dma_active   - copy engine wants the memory this cycle (RD/WR)
//   cpu_req      - CPU wants the memory this cycle
//   dma_gnt      - copy engine owns the memory this cycle
//   cpu_stall    - CPU request denied this cycle
module dat_mem_grant
    import dat_mem_ctrl_pkg::*;
#(
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_active,
    input  logic cpu_req,
    output logic dma_gnt,
    output logic cpu_stall
);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    // CPU normally wins; after STARVE_LIM consecutive losses the DMA takes one cycle.
    assign starved   = (starve_cnt == SW'(STARVE_LIM));
    assign dma_gnt   = dma_active & (~cpu_req | starved);
    assign cpu_stall = dma_active & cpu_req & starved;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dma_gnt) begin
            starve_cnt <= '0;
        end else if (dma_active && cpu_req) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/dat_mem_dma_ctrl.sv
// rtl/dat_mem_dma_ctrl.sv - data-memory scheduler sharing the memory between CPU and a block-copy engine
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   start, src_addr, dst_addr, len    - copy launch (sampled in IDLE only)
//   busy, done                        - copy in progress / one-cycle completion pulse
//   cpu_req, cpu_wr, cpu_addr,
//   cpu_wdata, cpu_memToReg           - CPU load/store path
//   cpu_stall                         - CPU denied this cycle
//   mem_addr, mem_wr_en, mem_din,
//   mem_memToReg, mem_dout            - memory interface (combinational read, clocked write)
module dat_mem_dma_ctrl
    import dat_mem_ctrl_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_memToReg,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_din,
    output logic          mem_memToReg,
    input  logic [DW-1:0] mem_dout
);

    state_t        state, state_nxt;
    logic [AW-1:0] src_q, dst_q, off_q, rem_q;
    logic [DW-1:0] hold_q;
    logic          dma_active, dma_gnt;

    assign busy = (state == RD) || (state == WR);
    assign done = (state == DONE);

    // A reset cycle must not let an in-flight WR reach the memory.
    assign dma_active = busy & ~reset;

    dat_mem_grant #(
        .STARVE_LIM(STARVE_LIM)
    ) u_grant (
        .clk       (clk),
        .reset     (reset),
        .dma_active(dma_active),
        .cpu_req   (cpu_req),
        .dma_gnt   (dma_gnt),
        .cpu_stall (cpu_stall)
    );

    always_comb begin
        state_nxt    = state;
        mem_addr     = cpu_addr;
        mem_din      = cpu_wdata;
        mem_wr_en    = cpu_req & cpu_wr;
        mem_memToReg = cpu_memToReg;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RD : DONE;
                end
            end
            RD: begin
                if (dma_gnt) begin
                    mem_addr     = src_q + off_q;
                    mem_wr_en    = 1'b0;
                    mem_memToReg = 1'b1;
                    state_nxt    = WR;
                end
            end
            WR: begin
                if (dma_gnt) begin
                    mem_addr     = dst_q + off_q;
                    mem_din      = hold_q;
                    mem_wr_en    = 1'b1;
                    mem_memToReg = 1'b0;
                    state_nxt    = (rem_q == AW'(1)) ? DONE : RD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            off_q  <= '0;
            rem_q  <= '0;
            hold_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start && len != '0) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                rem_q <= len;
                off_q <= '0;
            end
            if (state == RD && dma_gnt) begin
                hold_q <= mem_dout;
            end
            if (state == WR && dma_gnt) begin
                off_q <= off_q + AW'(1);
                rem_q <= rem_q - AW'(1);
            end
        end
    end

endmodule

// File: doc/dat_mem_dma_ctrl.md
Name: dat_mem_dma_ctrl

Overview:
- Controller and scheduler for the single-port 8x256 data memory.
- Shares the memory between the CPU load/store path and a block-copy (DMA) engine.
- The engine copies `len` bytes from `src_addr` to `dst_addr` using the memory's combinational read and clocked write.
- Sits between the core and the data memory and drives the memory's address, write-enable, write-data and `memToReg` select.

Parameters:
- AW, 8, address width (256-byte space)
- DW, 8, data width
- STARVE_LIM, 8, consecutive CPU-blocked DMA cycles before the DMA is force-granted one cycle (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch a copy; sampled only in IDLE
- src_addr  in  AW  copy source base
- dst_addr  in  AW  copy destination base
- len  in  AW  bytes to copy; 0 = no transfer
- busy  out  1  high while in RD or WR
- done  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU memory access this cycle
- cpu_wr  in  1  CPU store
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_memToReg  in  1  CPU load select (passed through)
- cpu_stall  out  1  CPU denied this cycle; CPU holds request
- mem_addr  out  AW  to memory addr
- mem_wr_en  out  1  to memory wr_en
- mem_din  out  DW  to memory dat_in
- mem_memToReg  out  1  to memory memToReg
- mem_dout  in  DW  from memory dat_out

Behaviour:
- Reset is synchronous and active-high; clock is `clk`.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, cpu_stall=0.
  - Byte counter, offset and hold register = 0.
  - Starve counter = 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - `start`=1 and `len`≠0: latch src/dst/len, offset=0, go to RD.
  - `start`=1 and `len`=0: go to DONE (no memory access).
  - `start` ignored in any other state.
- RD:
  - When granted: mem_addr=src+offset, mem_memToReg=1, wr_en=0.
  - Capture mem_dout into the hold register; go to WR.
  - When not granted: stay in RD.
- WR:
  - When granted: mem_addr=dst+offset, mem_din=hold, wr_en=1.
  - offset++, remaining--.
  - remaining reaches 0: go to DONE; else go to RD.
  - When not granted: stay in WR.
- DONE: done=1, busy=0 for one cycle, then IDLE.
- Address arithmetic is mod 256; src/dst wrap 255→0 silently.
- Overlapping regions copy strictly forward, byte by byte, with no overlap correction.
- Grant rule, each cycle with DMA in RD/WR:
  - cpu_req=0: DMA granted.
  - cpu_req=1 and starve_cnt<STARVE_LIM: CPU granted, starve_cnt++.
  - cpu_req=1 and starve_cnt==STARVE_LIM: DMA granted, cpu_stall=1 (combinational), memory ignores CPU.
  - Any DMA grant clears starve_cnt.
- Outside RD/WR:
  - CPU always granted; cpu_stall=0.
  - Memory driven from the cpu_* ports, with mem_wr_en=cpu_req&cpu_wr.
  - No CPU request: wr_en=0.
- Uncontended latency: start sampled at edge 0 → RD in cycle 1, WR in cycle 2, …, last WR in cycle 2·len → done high in cycle 2·len+1.
- Reset mid-transfer: abort immediately, no further writes; bytes already written remain; no done pulse.
- Simultaneous start and cpu_req in IDLE: the CPU access proceeds; the copy is still latched.

Decomposition:
- Package dat_mem_ctrl_pkg:
  - State enum (IDLE, RD, WR, DONE).
  - AW/DW constants.
  - Starve-counter width (4 bits).
- One sub-module, dat_mem_grant:
  - Starve counter plus the combinational grant/stall decision.
  - Inputs: dma_active, cpu_req.
  - Outputs: dma_gnt, cpu_stall.
- The FSM and datapath muxing stay in the top module.

Test Plan:
- Preload mem[0x10..0x13]=A1,B2,C3,D4; start src=0x10 dst=0x80 len=4, no CPU traffic → mem[0x80..0x83]=A1..D4; done pulses exactly in cycle 9; busy high in cycles 1–8.
- len=0 start → done in cycle 1, no mem_wr_en assertion, busy never high.
- Wrap: src=0xFE dst=0x01 len=4, mem[FE,FF,00,01]=11,22,33,44 → forward overlapping copy gives mem[01..04]=11,22,33,11 (mem[01] overwritten before it is read); addresses wrap FF→00.
- Contention, STARVE_LIM=8: cpu_req held high for 20 cycles during a len=2 copy → CPU granted 8 cycles, then cpu_stall=1 for 1 cycle with a DMA grant; pattern repeats; CPU stores land correctly; copy completes.
- Assert reset after the 2nd WR of a len=4 copy → state IDLE next cycle; only dst+0 and dst+1 written; no done pulse; busy=0.
- start pulsed again while busy → ignored; exactly one done pulse; destination contents unchanged from a single copy.
